// File: rtl/tl_pkg.sv
// tl_pkg: lamp codes, FSM state codes and dwell-counter
// sizing shared by the timed traffic-light controller.
package tl_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    LEFT   = 2'b10,
    RED    = 2'b11
  } lamp_t;

  typedef enum logic [2:0] {
    A_GRN  = 3'd0,
    A_YEL1 = 3'd1,
    A_LFT  = 3'd2,
    A_YEL2 = 3'd3,
    B_GRN  = 3'd4,
    B_YEL1 = 3'd5,
    B_LFT  = 3'd6,
    B_YEL2 = 3'd7
  } state_t;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic int cnt_w(
    input int y,
    input int m,
    input int x
  );
    return $clog2(max3(y, m, x) + 1);
  endfunction

endpackage

// File: rtl/tl_cntr_timed.sv
// tl_cntr_timed: two-road traffic light with left-turn
// phases, timed yellow and min/max green dwell.
module tl_cntr_timed
  import tl_pkg::*;
#(
  parameter int YEL_CYC   = 2,
  parameter int MIN_GRN   = 3,
  parameter int MAX_GRN   = 8,
  parameter int SKIP_LEFT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic [2:0] phase
);

  localparam int CMAX = max3(YEL_CYC, MIN_GRN, MAX_GRN);
  localparam int CW   = cnt_w(YEL_CYC, MIN_GRN, MAX_GRN);

  localparam logic [CW-1:0] CNT_MAX = CW'(CMAX);
  localparam logic [CW-1:0] MIN_END = CW'(MIN_GRN - 1);
  localparam logic [CW-1:0] YEL_END = CW'(YEL_CYC - 1);
  localparam logic [CW-1:0] MAX_END =
    CW'((MAX_GRN == 0) ? 0 : MAX_GRN - 1);

  localparam bit HAS_TMO = (MAX_GRN != 0);
  localparam bit SKIP    = (SKIP_LEFT != 0);

  if (YEL_CYC < 1) begin : g_bad_yel
    $error("tl_cntr_timed: YEL_CYC must be >= 1");
  end
  if (MIN_GRN < 1) begin : g_bad_min
    $error("tl_cntr_timed: MIN_GRN must be >= 1");
  end
  if (MAX_GRN != 0 && MAX_GRN < MIN_GRN) begin : g_bad_max
    $error("tl_cntr_timed: MAX_GRN must be 0 or >= MIN_GRN");
  end

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic          done_min;
  logic          tmo;
  logic          yel_end;

  assign done_min = (cnt >= MIN_END);
  assign tmo      = HAS_TMO && (cnt == MAX_END);
  assign yel_end  = (cnt == YEL_END);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= A_GRN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Sensors only matter on the edge that decides an exit.
  always_comb begin
    state_nx = state;
    unique case (state)
      A_GRN: begin
        if (done_min && (!Ta || tmo)) state_nx = A_YEL1;
      end
      A_YEL1: begin
        if (yel_end) begin
          if (Tal || !SKIP) state_nx = A_LFT;
          else              state_nx = B_GRN;
        end
      end
      A_LFT: begin
        if (done_min && (!Tal || tmo)) state_nx = A_YEL2;
      end
      A_YEL2: begin
        if (yel_end) state_nx = B_GRN;
      end
      B_GRN: begin
        if (done_min && (!Tb || tmo)) state_nx = B_YEL1;
      end
      B_YEL1: begin
        if (yel_end) begin
          if (Tbl || !SKIP) state_nx = B_LFT;
          else              state_nx = A_GRN;
        end
      end
      B_LFT: begin
        if (done_min && (!Tbl || tmo)) state_nx = B_YEL2;
      end
      B_YEL2: begin
        if (yel_end) state_nx = A_GRN;
      end
      default: state_nx = A_GRN;
    endcase
  end

  always_comb begin
    La = RED;
    Lb = RED;
    unique case (state)
      A_GRN:          La = GREEN;
      A_YEL1, A_YEL2: La = YELLOW;
      A_LFT:          La = LEFT;
      B_GRN:          Lb = GREEN;
      B_YEL1, B_YEL2: Lb = YELLOW;
      B_LFT:          Lb = LEFT;
      default: begin
        La = RED;
        Lb = RED;
      end
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_tl_cntr_timed.sv
// tb_tl_cntr_timed: default, no-skip and no-timeout builds
// driven by shared sensors and checked against a phase model.
module tb_tl_cntr_timed;
  import tl_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic ta = 1'b0;
  logic tal = 1'b0;
  logic tb = 1'b0;
  logic tbl = 1'b0;

  logic [1:0] la [3];
  logic [1:0] lb [3];
  logic [2:0] ph [3];

  int checks = 0;
  int failures = 0;

  localparam int P_YEL = 2;
  localparam int P_MIN = 3;
  int p_mx [3] = '{8, 8, 0};
  int p_sk [3] = '{1, 0, 1};

  int m_ph [3];
  int m_t  [3];

  always #3 clk = ~clk;

  tl_cntr_timed #(
    .YEL_CYC(2), .MIN_GRN(3), .MAX_GRN(8), .SKIP_LEFT(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .Ta(ta), .Tal(tal), .Tb(tb), .Tbl(tbl),
    .La(la[0]), .Lb(lb[0]), .phase(ph[0])
  );

  tl_cntr_timed #(
    .YEL_CYC(2), .MIN_GRN(3), .MAX_GRN(8), .SKIP_LEFT(0)
  ) dut_nl (
    .clk(clk), .reset_n(reset_n),
    .Ta(ta), .Tal(tal), .Tb(tb), .Tbl(tbl),
    .La(la[1]), .Lb(lb[1]), .phase(ph[1])
  );

  tl_cntr_timed #(
    .YEL_CYC(2), .MIN_GRN(3), .MAX_GRN(0), .SKIP_LEFT(1)
  ) dut_nt (
    .clk(clk), .reset_n(reset_n),
    .Ta(ta), .Tal(tal), .Tb(tb), .Tbl(tbl),
    .La(la[2]), .Lb(lb[2]), .phase(ph[2])
  );

  function automatic bit moving(input logic [1:0] l);
    return (l == GREEN) || (l == LEFT);
  endfunction

  assert property (@(negedge clk) disable iff (!reset_n)
    !(moving(la[0]) && moving(lb[0])))
  else $display("FAIL safety_assert dut0 La=%0d Lb=%0d", la[0], lb[0]);

  // Road-A lamp of a phase; road B is the same table rotated by four.
  function automatic int lamp_of(input int p);
    case (p)
      0:       return 0;
      1, 3:    return 1;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 3; i++) begin
      m_ph[i] = 0;
      m_t[i]  = 1;
    end
  endfunction

  // m_t counts cycles already spent in the phase, starting at 1.
  function automatic void m_step(input int i);
    int p;
    int nx;
    bit go;
    bit own;
    bit lft;
    p   = m_ph[i];
    own = (p < 4) ? ((p == 0) ? ta : tal) : ((p == 4) ? tb : tbl);
    lft = (p < 4) ? tal : tbl;
    if (p % 4 == 0 || p % 4 == 2)
      go = (m_t[i] >= P_MIN) &&
           (!own || (p_mx[i] != 0 && m_t[i] >= p_mx[i]));
    else
      go = (m_t[i] >= P_YEL);
    case (p % 4)
      1:       nx = (lft || p_sk[i] == 0) ? p + 1 : (p + 3) % 8;
      3:       nx = (p + 1) % 8;
      default: nx = p + 1;
    endcase
    if (go) begin
      m_ph[i] = nx;
      m_t[i]  = 1;
    end else begin
      m_t[i]  = m_t[i] + 1;
    end
  endfunction

  task automatic expect_eq(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, got, want, $time);
    end
  endtask

  task automatic check_models();
    for (int i = 0; i < 3; i++) begin
      expect_eq($sformatf("phase_dut%0d", i), int'(ph[i]), m_ph[i]);
      expect_eq($sformatf("la_dut%0d", i), int'(la[i]), lamp_of(m_ph[i]));
      expect_eq($sformatf("lb_dut%0d", i), int'(lb[i]),
                lamp_of((m_ph[i] + 4) % 8));
      expect_eq($sformatf("safety_dut%0d", i),
                int'(moving(la[i]) && moving(lb[i])), 0);
    end
  endtask

  task automatic cycle(input logic [3:0] s);
    check_models();
    {ta, tal, tb, tbl} = s;
    for (int i = 0; i < 3; i++) m_step(i);
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] s;
    int         n;
    logic [2:0] ph;
  } vec_t;

  vec_t vt [22];

  initial begin
    vt[0]  = '{4'b0000, 3, 3'd0};
    vt[1]  = '{4'b0000, 2, 3'd1};
    vt[2]  = '{4'b0000, 3, 3'd4};
    vt[3]  = '{4'b0000, 2, 3'd5};
    vt[4]  = '{4'b1000, 8, 3'd0};
    vt[5]  = '{4'b0000, 1, 3'd1};
    vt[6]  = '{4'b0100, 1, 3'd1};
    vt[7]  = '{4'b0000, 3, 3'd2};
    vt[8]  = '{4'b0000, 2, 3'd3};
    vt[9]  = '{4'b0010, 8, 3'd4};
    vt[10] = '{4'b0001, 2, 3'd5};
    vt[11] = '{4'b0001, 8, 3'd6};
    vt[12] = '{4'b0000, 2, 3'd7};
    vt[13] = '{4'b0000, 3, 3'd0};
    vt[14] = '{4'b0100, 1, 3'd1};
    vt[15] = '{4'b0000, 1, 3'd1};
    vt[16] = '{4'b0000, 3, 3'd4};
    vt[17] = '{4'b0000, 2, 3'd5};
    vt[18] = '{4'b1000, 4, 3'd0};
    vt[19] = '{4'b0000, 1, 3'd0};
    vt[20] = '{4'b0000, 2, 3'd1};
    vt[21] = '{4'b0000, 1, 3'd4};

    #1 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      expect_eq($sformatf("rst_phase_dut%0d", i), int'(ph[i]), 0);
      expect_eq($sformatf("rst_la_dut%0d", i), int'(la[i]), 0);
      expect_eq($sformatf("rst_lb_dut%0d", i), int'(lb[i]), 3);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();

    for (int v = 0; v < 22; v++) begin
      for (int k = 0; k < vt[v].n; k++) begin
        expect_eq($sformatf("vec%0d_cyc%0d", v, k),
                  int'(ph[0]), int'(vt[v].ph));
        cycle(vt[v].s);
      end
    end

    begin
      int k;
      k = 0;
      while (ph[2] != 3'd4 && k < 40) begin
        cycle(4'b0010);
        k++;
      end
      expect_eq("nt_reach_bgrn_timeout", int'(ph[2]), 4);
      for (int j = 0; j < 120; j++) cycle(4'b0010);
      expect_eq("nt_hold_lb_green", int'(lb[2]), 0);
      expect_eq("nt_hold_phase", int'(ph[2]), 4);
      cycle(4'b0000);
      expect_eq("nt_drop_lb_yellow", int'(lb[2]), 1);
    end

    begin
      logic [3:0] s;
      s = 4'b0000;
      for (int j = 0; j < 3000; j++) begin
        if ($urandom_range(3) == 0) s = 4'($urandom_range(15));
        cycle(s);
      end
    end

    begin
      int k;
      k = 0;
      while (ph[0] != 3'd6 && k < 40) begin
        cycle(4'b0001);
        k++;
      end
      expect_eq("reach_blft_timeout", int'(ph[0]), 6);
      #1 reset_n = 1'b0;
      #1;
      expect_eq("midrst_phase", int'(ph[0]), 0);
      expect_eq("midrst_la", int'(la[0]), 0);
      expect_eq("midrst_lb", int'(lb[0]), 3);
      m_reset();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int j = 0; j < 12; j++) cycle(4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
